// File: rtl/k30p_bus_pkg.sv
// ---------------------------------------------------------------------------
// k30p_bus_pkg
//
// Shared definitions for the k30p 68030 bus-cycle logic.
//   bus_state_e    : states of the cycle terminator FSM
//   bus_dev_e      : which decoded device owns the current cycle
//   DSACK_32/16/8  : (dsack_1, dsack_0) port-size termination patterns,
//                    0 = asserted (driven low), 1 = negated (left at Z)
//   dsack_pattern  : maps a device to its port-size pattern
//   select_device  : applies the rom > ram > io > vme decode priority
// ---------------------------------------------------------------------------
package k30p_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACK     = 3'd2,
        ST_NEGATE  = 3'd3,
        ST_TIMEOUT = 3'd4
    } bus_state_e;

    typedef enum logic [2:0] {
        DEV_NONE = 3'd0,
        DEV_ROM  = 3'd1,
        DEV_RAM  = 3'd2,
        DEV_IO   = 3'd3,
        DEV_VME  = 3'd4
    } bus_dev_e;

    // Bit 1 is dsack_1, bit 0 is dsack_0; a 0 means that strobe is asserted.
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    function automatic logic [1:0] dsack_pattern(input bus_dev_e dev);
        logic [1:0] pat;
        case (dev)
            DEV_ROM: pat = DSACK_8;
            DEV_RAM: pat = DSACK_32;
            DEV_IO:  pat = DSACK_8;
            DEV_VME: pat = DSACK_16;
            default: pat = DSACK_NONE;
        endcase
        return pat;
    endfunction

    function automatic bus_dev_e select_device(input logic rom, input logic ram,
                                               input logic io, input logic vme);
        bus_dev_e dev;
        if (rom)      dev = DEV_ROM;
        else if (ram) dev = DEV_RAM;
        else if (io)  dev = DEV_IO;
        else if (vme) dev = DEV_VME;
        else          dev = DEV_NONE;
        return dev;
    endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
//
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VALUE so an inactive-high (active-low) bus signal reads as negated
// while the system is in reset.
//   clock_i  : destination clock
//   reset_i  : asynchronous, active-high reset
//   async_i  : asynchronous input
//   sync_o   : input re-timed to clock_i, two-cycle latency
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/dsack_generator.sv
// ---------------------------------------------------------------------------
// dsack_generator
//
// Bus-cycle terminator for the k30p 68030 controller. Watches the CPU
// address strobe and the decoded selects, counts per-device wait states and
// then terminates the cycle on DSACK1/DSACK0 with the port-size encoding of
// the selected device. Cycles nobody answers end in a bus error.
//
// Ports
//   clock              : CPU clock, rising edge
//   reset              : asynchronous, active-high
//   cpu_address_strobe : active-low AS, synchronous to clock
//   rom_select         : 8-bit port, ROM_WAIT wait states
//   ram_select         : 32-bit port, RAM_WAIT wait states
//   io_select          : 8-bit port, IO_WAIT wait states
//   vme_select         : 16-bit port, terminated by vme_dtack
//   vme_dtack          : active-low VME DTACK, asynchronous
//   dsack_0, dsack_1   : active-low, open-drain style tri-state outputs
//   bus_error          : active-low BERR, tri-state
// ---------------------------------------------------------------------------
module dsack_generator
    import k30p_bus_pkg::*;
#(
    parameter int ROM_WAIT       = 3,
    parameter int RAM_WAIT       = 1,
    parameter int IO_WAIT        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_address_strobe,
    input  logic rom_select,
    input  logic ram_select,
    input  logic io_select,
    input  logic vme_select,
    input  logic vme_dtack,
    inout  wire  dsack_0,
    inout  wire  dsack_1,
    inout  wire  bus_error
);

    localparam int MAX_WAIT_RI = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int MAX_WAIT    = (MAX_WAIT_RI > IO_WAIT) ? MAX_WAIT_RI : IO_WAIT;
    localparam int WAIT_W      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int TMO_W       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    // Strobe mask bit positions: {bus_error, dsack_1, dsack_0}
    localparam int BERR_BIT = 2;

    if (TIMEOUT_CYCLES <= MAX_WAIT) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must exceed every wait-state count");
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    bus_state_e        state_q, state_d;
    bus_dev_e          dev_q,   dev_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [TMO_W-1:0]  tmo_q,   tmo_d;
    // Strobes this cycle pulled low; NEGATE drives exactly these back high.
    logic [2:0]        drv_q,   drv_d;

    logic              dtack_sync;
    logic              as_low;
    logic              ack_ready;
    logic [TMO_W-1:0]  tmo_inc;
    logic              tmo_hit;

    sync2 #(
        .RESET_VALUE (1'b1)
    ) u_dtack_sync (
        .clock_i (clock),
        .reset_i (reset),
        .async_i (vme_dtack),
        .sync_o  (dtack_sync)
    );

    function automatic logic [WAIT_W-1:0] wait_load(input bus_dev_e dev);
        logic [WAIT_W-1:0] w;
        case (dev)
            DEV_ROM: w = WAIT_W'(ROM_WAIT);
            DEV_RAM: w = WAIT_W'(RAM_WAIT);
            DEV_IO:  w = WAIT_W'(IO_WAIT);
            default: w = '0;   // VME waits on DTACK, unselected waits on timeout
        endcase
        return w;
    endfunction

    assign as_low = ~cpu_address_strobe;

    // Timeout counter saturates at its limit rather than wrapping.
    assign tmo_inc = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_W'(1);
    assign tmo_hit = (tmo_inc == TMO_LIMIT);

    // Local devices finish on an expired wait count; VME finishes on DTACK.
    // An unselected cycle never becomes ready and must time out.
    always_comb begin
        ack_ready = 1'b0;
        case (dev_q)
            DEV_VME:  ack_ready = ~dtack_sync;
            DEV_NONE: ack_ready = 1'b0;
            default:  ack_ready = (wait_q == '0);
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        drv_d   = drv_q;

        case (state_q)
            ST_IDLE: begin
                if (as_low) begin
                    dev_d   = select_device(rom_select, ram_select, io_select, vme_select);
                    wait_d  = wait_load(dev_d);
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                tmo_d = tmo_inc;
                if (!as_low) begin
                    // CPU abandoned the cycle; nothing was driven, so skip NEGATE.
                    state_d = ST_IDLE;
                end else if (ack_ready) begin
                    // Termination takes precedence over a coincident timeout.
                    state_d = ST_ACK;
                    drv_d   = {1'b0, ~dsack_pattern(dev_q)};
                end else begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                    if (tmo_hit) begin
                        state_d = ST_TIMEOUT;
                        drv_d   = 3'b000;
                        drv_d[BERR_BIT] = 1'b1;
                    end
                end
            end

            ST_ACK, ST_TIMEOUT: begin
                if (!as_low) begin
                    state_d = ST_NEGATE;
                end
            end

            ST_NEGATE: begin
                // AS seen low here belongs to the next cycle and is picked up
                // from IDLE on the following edge.
                state_d = ST_IDLE;
                drv_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                drv_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dev_q   <= DEV_NONE;
            wait_q  <= '0;
            tmo_q   <= '0;
            drv_q   <= '0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            drv_q   <= drv_d;
        end
    end

    // ------------------------------------------------------------------
    // Tri-state strobe drivers
    // ------------------------------------------------------------------
    // Decoded from registered state so reset releases the bus immediately.
    logic [2:0] drive_en;
    logic       drive_high;

    always_comb begin
        drive_en   = '0;
        drive_high = 1'b0;
        case (state_q)
            ST_ACK, ST_TIMEOUT: drive_en = drv_q;
            ST_NEGATE: begin
                drive_en   = drv_q;
                drive_high = 1'b1;   // actively restore the line before release
            end
            default: drive_en = '0;
        endcase
    end

    assign dsack_0   = drive_en[0]        ? drive_high : 1'bz;
    assign dsack_1   = drive_en[1]        ? drive_high : 1'bz;
    assign bus_error = drive_en[BERR_BIT] ? drive_high : 1'bz;

endmodule

// File: doc/dsack_generator.md
# dsack_generator

Bus-cycle terminator for the k30p 68030 controller CPLD. It watches the CPU address strobe and the decoded device selects, inserts a per-device number of wait states, then terminates the cycle by driving the 68030 DSACK1/DSACK0 pair with the correct port-size encoding. Unanswered cycles get a bus error. It sits beside `buslogic` on the same strobe and clock, consuming `cpu_address_strobe` and closing the cycles that `buslogic` opens.

## Interface
- `ROM_WAIT`, 3: wait states for ROM cycles.
- `RAM_WAIT`, 1: wait states for RAM cycles.
- `IO_WAIT`, 4: wait states for on-board I/O cycles.
- `TIMEOUT_CYCLES`, 64: cycles from strobe assertion to bus error; must be greater than every `*_WAIT`.

- `clock`  in  1  CPU clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_address_strobe`  in  1  active-low AS from the 68030, synchronous to `clock`.
- `rom_select`  in  1  active-high decode, 8-bit port.
- `ram_select`  in  1  active-high decode, 32-bit port.
- `io_select`  in  1  active-high decode, 8-bit port.
- `vme_select`  in  1  active-high decode, 16-bit port, terminated by `vme_dtack`.
- `vme_dtack`  in  1  active-low DTACK from the VME bus, asynchronous.
- `dsack_0`  inout  1  active-low, tri-stated when not driving.
- `dsack_1`  inout  1  active-low, tri-stated when not driving.
- `bus_error`  inout  1  active-low BERR, tri-stated when not driving.

## Operation
- States: IDLE, WAIT, ACK, NEGATE, TIMEOUT.
- **IDLE**
  - All three strobes at Z.
  - On an edge where AS is sampled low: latch the select with priority rom > ram > io > vme, load the wait counter with that device's `*_WAIT`, clear the timeout counter, and go to WAIT.
  - VME cycles load 0 into the wait counter and wait on synced DTACK instead.
  - No select asserted: the cycle can only end by timeout.
- **WAIT**
  - Each edge, the timeout counter increments.
  - ROM/RAM/IO: if the wait count is 0, go to ACK; otherwise decrement it.
  - VME: go to ACK when synced `vme_dtack` is low.
  - If the timeout counter reaches `TIMEOUT_CYCLES` on this edge, go to TIMEOUT. A simultaneous ACK condition wins.
  - AS sampled high: the cycle was aborted; go directly to IDLE with no strobe driven.
- **ACK**
  - Drive the port-size pattern (dsack_1, dsack_0): 32-bit = 0,0; 16-bit = 0,1; 8-bit = 1,0.
  - Hold until AS is sampled high, then go to NEGATE.
- **TIMEOUT**
  - Drive `bus_error` low, DSACKs at Z.
  - Hold until AS is sampled high, then go to NEGATE.
- **NEGATE**
  - Actively drive every strobe that was low to 1 for one cycle, then return to IDLE at Z.
  - An AS assertion sampled in NEGATE is not accepted; it is accepted from IDLE on the next edge.
- Reset, asserted at any time: state IDLE, counters 0, all strobes Z, synchronizer flops 1.

## Timing
- AS sampled low at edge N: ACK is entered at edge N+1+W, where W is the device's wait count. The DSACK drive appears after that edge.
- VME: DSACK appears 1 cycle after synced DTACK is seen low. The synchronizer adds 2 cycles from the raw DTACK edge.
- Bus error: `bus_error` drives low after edge N+`TIMEOUT_CYCLES`.
- Release: AS sampled high at edge M gives NEGATE after M, Z after M+1.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- Wait counter width is sized to the largest `*_WAIT`.

## Structure
- Shared package `k30p_bus_pkg` holds:
  - the state enum;
  - port-size constants `DSACK_32`, `DSACK_16`, `DSACK_8` as 2-bit (dsack_1, dsack_0) patterns.
- Sub-module `sync2`: a two-flop synchronizer for `vme_dtack`, reset to 1, reusable for other asynchronous VME inputs.

## Test plan
- RAM cycle: AS low at edge 10 with `ram_select` -> dsack_1 = dsack_0 = 0 after edge 12. AS high at edge 15 -> both driven 1 after edge 15, Z after edge 16.
- ROM cycle with defaults -> dsack_0 = 0 and dsack_1 = Z-released after edge 14. Repeat with `rom_select` and `io_select` both asserted -> ROM timing is used.
- VME cycle: raw DTACK falls 7 cycles after AS -> dsack_1 = 0, dsack_0 = 1 exactly 3 edges after the DTACK fall.
- Unselected access: AS low at edge 0, no select -> `bus_error` low after edge 64, DSACKs Z throughout. Releases through NEGATE after AS rises.
- Abort: AS rises during an IO wait -> no strobe ever driven, IDLE next edge. Then a back-to-back RAM cycle terminates normally.
- Reset asserted while in ACK -> strobes Z immediately, no clock edge needed. After release, the next cycle behaves normally.
